// File: rtl/line_mem_arbiter.sv
// Shares one line-granular memory port between the instruction and data caches.
// One transaction at a time; when both request, the side not granted last time wins.
module line_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_addr,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_last_d;
    logic                  r_pmem_read;
    logic                  r_pmem_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [LINE_WIDTH-1:0] r_wdata;

    logic w_d_req;
    logic w_i_req;
    logic w_grant_d;

    assign w_d_req   = d_read | d_write;
    assign w_i_req   = i_read;
    // Data wins when alone, or on a conflict when instruction was granted last.
    assign w_grant_d = w_d_req & (~w_i_req | ~r_last_d);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_d     <= 1'b0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_d_req || w_i_req) begin
                        if (w_grant_d) begin
                            r_state      <= SERVE_D;
                            r_addr       <= d_addr;
                            r_wdata      <= d_wdata;
                            r_pmem_write <= d_write;
                            r_pmem_read  <= ~d_write;
                            r_last_d     <= 1'b1;
                        end else begin
                            r_state      <= SERVE_I;
                            r_addr       <= i_addr;
                            r_pmem_write <= 1'b0;
                            r_pmem_read  <= 1'b1;
                            r_last_d     <= 1'b0;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        r_state      <= IDLE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_read  = r_pmem_read;
    assign pmem_write = r_pmem_write;
    assign pmem_addr  = r_addr;
    assign pmem_wdata = r_wdata;

    assign i_resp  = (r_state == SERVE_I) & pmem_resp;
    assign d_resp  = (r_state == SERVE_D) & pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

`ifndef SYNTHESIS
    // A simultaneous read and write from the data cache is served as a write.
    a_d_rw_exclusive: assert property (@(posedge clk) disable iff (reset) !(d_read && d_write));
`endif

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Scoreboard bench for line_mem_arbiter: requesters push expectations, a monitor
// checks grants, latched pmem outputs and routed responses against a reference.
module tb_line_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned LW = 256;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_read = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read = 1'b0;
    logic          d_write = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [LW-1:0] d_wdata = '0;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_addr;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    line_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          wr;
        logic [LW-1:0] wdata;
        logic [LW-1:0] rdata;
    } req_t;

    req_t q_i[$];
    req_t q_d[$];
    bit   grant_log[$];
    logic [LW-1:0] ref_mem [logic [AW-1:0]];
    logic [LW-1:0] dev_mem [logic [AW-1:0]];

    int n_chk  = 0;
    int n_pass = 0;
    int fixed_lat = -1;
    bit force_resp = 1'b0;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [LW-1:0] init_line(input logic [AW-1:0] a);
        return {8{a ^ 32'h5A5A_0F0F}};
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        for (int unsigned k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    function automatic logic [LW-1:0] ref_line(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_line(a);
    endfunction

    function automatic void push_i(input logic [AW-1:0] a);
        req_t r;
        r.addr = a; r.wr = 1'b0; r.wdata = '0; r.rdata = ref_line(a);
        q_i.push_back(r);
    endfunction

    function automatic void push_d(input logic [AW-1:0] a, input logic wr, input logic [LW-1:0] wd);
        req_t r;
        r.addr = a; r.wr = wr; r.wdata = wd; r.rdata = ref_line(a);
        if (wr) ref_mem[a] = wd;
        q_d.push_back(r);
    endfunction

    // Memory device: responds after a fixed or random number of cycles.
    initial begin : device
        bit busy;
        int cnt;
        busy = 1'b0;
        cnt = 0;
        forever begin
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (reset) busy = 1'b0;
            else if (force_resp) begin
                pmem_resp = 1'b1;
                force_resp = 1'b0;
            end else if (pmem_read || pmem_write) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
                end
                if (cnt == 0) begin
                    if (pmem_write) begin
                        dev_mem[pmem_addr] = pmem_wdata;
                        pmem_rdata = rand_line();
                    end else begin
                        pmem_rdata = dev_mem.exists(pmem_addr) ? dev_mem[pmem_addr] : init_line(pmem_addr);
                    end
                    pmem_resp = 1'b1;
                    busy = 1'b0;
                end else cnt--;
            end else busy = 1'b0;
        end
    end

    // Monitor: I addresses have bit 31 clear, D addresses have it set.
    initial begin : monitor
        bit txn_active, txn_d, exp_idle, stable, last_d, prev_i, prev_d, exp_d, obs_d, ei, ed;
        logic strobe;
        req_t head, r;
        logic [AW-1:0] sv_addr;
        logic [LW-1:0] sv_wdata;
        logic sv_rd, sv_wr;
        txn_active = 0; txn_d = 0; exp_idle = 0; stable = 1; last_d = 0; prev_i = 0; prev_d = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                txn_active = 0; exp_idle = 0; last_d = 0; prev_i = 0; prev_d = 0;
            end else begin
                strobe = pmem_read | pmem_write;
                if (exp_idle) begin
                    chk("strobe_drop_after_resp", strobe, 1'b0);
                    exp_idle = 0;
                end else if (strobe && !txn_active) begin
                    obs_d = pmem_addr[31];
                    exp_d = (prev_i && prev_d) ? !last_d : prev_d;
                    chk("grant_had_request", prev_i | prev_d, 1'b1);
                    chk("grant_side", obs_d, exp_d);
                    last_d = exp_d;
                    grant_log.push_back(obs_d);
                    chk("grant_pending", (obs_d ? q_d.size() : q_i.size()) > 0, 1'b1);
                    if ((obs_d ? q_d.size() : q_i.size()) > 0) begin
                        head = obs_d ? q_d[0] : q_i[0];
                        chk("pmem_addr", pmem_addr, head.addr);
                        chk("pmem_write", pmem_write, head.wr);
                        chk("pmem_read", pmem_read, !head.wr);
                        if (head.wr) chk("pmem_wdata", pmem_wdata, head.wdata);
                    end
                    sv_addr = pmem_addr; sv_wdata = pmem_wdata; sv_rd = pmem_read; sv_wr = pmem_write;
                    txn_active = 1; txn_d = obs_d; stable = 1;
                end else if (txn_active) begin
                    if (!strobe) begin
                        chk("strobe_held", strobe, 1'b1);
                        txn_active = 0;
                    end else if (pmem_addr !== sv_addr || pmem_wdata !== sv_wdata ||
                                 pmem_read !== sv_rd || pmem_write !== sv_wr) stable = 0;
                end
                if (pmem_resp || i_resp || d_resp) begin
                    ei = pmem_resp && txn_active && !txn_d;
                    ed = pmem_resp && txn_active && txn_d;
                    chk("i_resp", i_resp, ei);
                    chk("d_resp", d_resp, ed);
                    if (ei && q_i.size() > 0) begin
                        r = q_i.pop_front();
                        chk("i_rdata", i_rdata, r.rdata);
                    end
                    if (ed && q_d.size() > 0) begin
                        r = q_d.pop_front();
                        if (!r.wr) chk("d_rdata", d_rdata, r.rdata);
                    end
                    if (txn_active && pmem_resp) begin
                        chk("pmem_outputs_stable", stable, 1'b1);
                        txn_active = 0;
                        exp_idle = 1;
                    end
                end
                prev_i = i_read;
                prev_d = d_read | d_write;
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    task automatic wait_resp(input bit side_d, input string nm);
        int unsigned n;
        logic got;
        n = 0; got = 1'b0;
        while (!got && n < 300) begin
            @(negedge clk);
            n++;
            got = side_d ? d_resp : i_resp;
        end
        chk(nm, got, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run_i(input int n, input int maxgap);
        logic [AW-1:0] a;
        repeat (n) begin
            repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
            a = {16'h0, 7'h0, 4'($urandom_range(0, 15)), 5'h0};
            push_i(a);
            i_addr = a; i_read = 1'b1;
            wait_resp(1'b0, "i_done");
            i_read = 1'b0;
        end
    endtask

    task automatic run_d(input int n, input int maxgap);
        logic [AW-1:0] a;
        logic [LW-1:0] wd;
        logic wr;
        repeat (n) begin
            repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
            a = {1'b1, 23'h0, 3'($urandom_range(0, 7)), 5'h0};
            wr = 1'($urandom_range(0, 1));
            wd = rand_line();
            push_d(a, wr, wd);
            d_addr = a; d_wdata = wd; d_write = wr; d_read = !wr;
            wait_resp(1'b1, "d_done");
            d_read = 1'b0; d_write = 1'b0;
        end
    endtask

    initial begin : main
        int unsigned n;
        logic [AW-1:0] a;
        logic [LW-1:0] wd;
        logic [3:0] order;

        // Reset state
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_pmem_addr", pmem_addr, '0);
        chk("rst_pmem_wdata", pmem_wdata, '0);
        chk("rst_i_resp", i_resp, 1'b0);
        chk("rst_d_resp", d_resp, 1'b0);

        // 1: single I read, memory latency 3
        @(posedge clk); #1;
        fixed_lat = 3;
        push_i(32'h0000_0060);
        i_addr = 32'h0000_0060; i_read = 1'b1;
        @(negedge clk);
        chk("t1_no_strobe_c0", pmem_read, 1'b0);
        @(negedge clk);
        chk("t1_strobe_c1", pmem_read, 1'b1);
        chk("t1_addr_c1", pmem_addr, 32'h0000_0060);
        n = 0;
        do begin @(negedge clk); n++; end while (!i_resp && n < 50);
        chk("t1_i_resp_latency", n, 3);
        chk("t1_d_resp_quiet", d_resp, 1'b0);
        @(posedge clk); #1;
        i_read = 1'b0;

        // 2: simultaneous I read and D write after reset, D first
        do_reset();
        fixed_lat = 2;
        wd = rand_line();
        push_d(32'h8000_0100, 1'b1, wd);
        push_i(32'h0000_0040);
        d_addr = 32'h8000_0100; d_wdata = wd; d_write = 1'b1;
        i_addr = 32'h0000_0040; i_read = 1'b1;
        wait_resp(1'b1, "t2_d_done");
        d_write = 1'b0;
        @(negedge clk);
        chk("t2_idle_after_d", pmem_read | pmem_write, 1'b0);
        @(negedge clk);
        chk("t2_i_strobe_k2", pmem_read, 1'b1);
        wait_resp(1'b0, "t2_i_done");
        i_read = 1'b0;

        // 3: continuous requests from both sides alternate D, I, D, I
        do_reset();
        fixed_lat = -1;
        grant_log.delete();
        fork
            run_i(2, 0);
            run_d(2, 0);
        join
        chk("t3_grant_count", grant_log.size(), 4);
        order = '0;
        for (int k = 0; k < 4 && k < grant_log.size(); k++) order[3-k] = grant_log[k];
        chk("t3_grant_order", order, 4'b1010);

        // 4: D inputs change mid-transaction; latched values must hold
        fixed_lat = 4;
        a = 32'h8000_00A0;
        wd = rand_line();
        push_d(a, 1'b1, wd);
        d_addr = a; d_wdata = wd; d_write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        d_addr = ~a; d_wdata = ~wd;
        @(negedge clk);
        chk("t4_addr_hold", pmem_addr, a);
        chk("t4_wdata_hold", pmem_wdata, wd);
        wait_resp(1'b1, "t4_d_done");
        d_write = 1'b0;

        // 5: asynchronous reset during SERVE_I, then re-arbitration
        fixed_lat = 6;
        push_i(32'h0000_0080);
        i_addr = 32'h0000_0080; i_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t5_strobe_before_rst", pmem_read, 1'b1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("t5_rst_drops_read", pmem_read, 1'b0);
        chk("t5_rst_no_i_resp", i_resp, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        fixed_lat = 2;
        wait_resp(1'b0, "t5_i_done");
        i_read = 1'b0;

        // 6: pmem_resp while idle is ignored
        @(negedge clk);
        force_resp = 1'b1;
        @(negedge clk);
        chk("t6_pmem_resp_seen", pmem_resp, 1'b1);
        chk("t6_no_resp", {i_resp, d_resp}, 2'b00);
        @(negedge clk);
        chk("t6_stays_idle", pmem_read | pmem_write, 1'b0);

        // Random traffic from both sides
        @(posedge clk); #1;
        fixed_lat = -1;
        fork
            run_i(25, 3);
            run_d(25, 3);
        join
        repeat (3) @(negedge clk);
        chk("final_q_i_empty", q_i.size(), 0);
        chk("final_q_d_empty", q_d.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
- Shares one line-granular physical memory port between the instruction cache and the data cache.
- Sits between the two caches that serve the pipeline's inst/data ports and the single lower-level memory.
- Arbitrates between requests, latches the winning request, and sequences exactly one memory transaction at a time.
- Routes the response back only to the winning requester.

Parameters:
ADDR_WIDTH, 32, byte address width of all address ports
LINE_WIDTH, 256, cache line width in bits for all data ports

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
i_read  input  1  icache line read request, held until i_resp
i_addr  input  ADDR_WIDTH  icache line address
i_rdata  output  LINE_WIDTH  line returned to icache
i_resp  output  1  icache transaction complete, one-cycle pulse
d_read  input  1  dcache line read request, held until d_resp
d_write  input  1  dcache line write-back request, held until d_resp
d_addr  input  ADDR_WIDTH  dcache line address
d_wdata  input  LINE_WIDTH  dcache write-back line
d_rdata  output  LINE_WIDTH  line returned to dcache
d_resp  output  1  dcache transaction complete, one-cycle pulse
pmem_read  output  1  memory read strobe
pmem_write  output  1  memory write strobe
pmem_addr  output  ADDR_WIDTH  memory address
pmem_wdata  output  LINE_WIDTH  memory write data
pmem_rdata  input  LINE_WIDTH  memory read data
pmem_resp  input  1  memory transaction complete

Behaviour:
Reset:
- Asynchronous, active-high; takes effect immediately, mid-transaction included.
- State returns to IDLE and last_grant returns to INST.
- pmem_read, pmem_write, i_resp and d_resp go to 0 immediately.
- Latched pmem_addr and pmem_wdata go to 0.
- An aborted transaction is never reported: no resp is issued for it.

State machine:
- States: IDLE, SERVE_I, SERVE_D.

IDLE:
- pmem_read and pmem_write are 0.
- pmem_resp is ignored.
- Arbitration uses d_req = d_read | d_write and i_req = i_read.
  - Only d_req: go to SERVE_D.
  - Only i_req: go to SERVE_I.
  - Both: grant the requester opposite to last_grant. After reset, last_grant = INST, so data wins the first conflict.
- At the granting edge, the block latches:
  - addr and, for data, wdata;
  - the operation: write when d_write, else read;
  - last_grant, updated to the winner.

SERVE_x:
- pmem_read or pmem_write is driven from the latched operation.
- pmem_addr and pmem_wdata are driven from the latched values.
- These outputs are registered: stable for the whole transaction even if the requester's inputs change.
- The non-granted requester waits. Its resp stays 0 and its request is not latched.
- On pmem_resp = 1:
  - x_resp = 1 in the same cycle (combinational from pmem_resp and state).
  - Next state is IDLE.
  - pmem strobes are 0 from the next cycle.

Data return:
- i_rdata and d_rdata are continuous copies of pmem_rdata.
- Data is valid only in the cycle the matching resp is high.

Latency:
- A request seen in IDLE in cycle 0 gives a pmem strobe in cycle 1.
- pmem_resp in cycle k gives x_resp in cycle k and IDLE in cycle k+1.
- The earliest next strobe is cycle k+2.

Requester obligations:
- Keep the request asserted until resp.
- Deassert or change the request in the cycle after resp. A request still high in that IDLE cycle is treated as a new request.

Boundary conditions:
- d_read & d_write together: treated as a write; the simulation assertion fires.
- pmem_resp in IDLE: ignored; no resp is generated.
- Fairness: under continuous requests from both sides, grants strictly alternate D, I, D, I. Neither side waits more than one transaction.

Test Plan:
1. Reset, then i_read=1 with i_addr=0x0000_0060; memory responds 3 cycles after the strobe with rdata=L1 -> pmem_read=1 and pmem_addr=0x60 from cycle 1; i_resp pulses for one cycle with i_rdata=L1; d_resp stays 0.
2. i_read and d_write rise in the same cycle right after reset, d_addr=0x100, d_wdata=W -> D is served first (pmem_write=1, addr 0x100, wdata W); I is served next, with pmem_read beginning 2 cycles after d_resp.
3. Both requests held continuously across 4 transactions -> grant order D, I, D, I; exactly one resp per transaction, to the correct side.
4. d_addr and d_wdata change mid-SERVE_D before pmem_resp -> pmem_addr and pmem_wdata stay at the latched values for the whole transaction.
5. Assert reset asynchronously (between clock edges) during SERVE_I -> pmem_read drops before the next edge; no i_resp; after release, the held i_read is re-arbitrated from IDLE.
6. pmem_resp pulsed while in IDLE with no requests -> no i_resp or d_resp; state stays IDLE.
